// File: rtl/ysyx_22041071_ex_stage.sv
// Execute stage: ALU, branch resolution, iterative 64-bit divider and the EX/MEM
// pipeline register behind a valid/ready handshake.
module ysyx_22041071_ex_stage #(
  parameter int XLEN       = 64,
  parameter int DIV_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid4,
  output logic            ready4,
  input  logic [XLEN-1:0] PC4,
  input  logic [31:0]     Ins3,
  input  logic            Brch2,
  input  logic            MEM_W_en2,
  input  logic            WB_sel2,
  input  logic [4:0]      ALU_ctrl2,
  input  logic            reg_w_en2,
  input  logic [XLEN-1:0] rt_data1,
  input  logic [4:0]      rdest1,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [11:0]     BImm2,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rdest1_,
  output logic            reg_w_en3_,
  output logic            Brch_taken,
  output logic [XLEN-1:0] Brch_PC,
  input  logic            ready5,
  output logic            valid5,
  output logic [XLEN-1:0] PC5,
  output logic [31:0]     Ins4,
  output logic            MEM_W_en3,
  output logic            WB_sel3,
  output logic            reg_w_en3,
  output logic [4:0]      rdest2_o,
  output logic [XLEN-1:0] result1,
  output logic [XLEN-1:0] rt_data2
);
  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_reg, state_next;

  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [XLEN-1:0] quo_reg, quo_next, rem_reg, rem_next, dsr_reg, dsr_next;
  logic            neg_q_reg, neg_q_next, neg_r_reg, neg_r_next;
  logic            is_rem_reg, is_rem_next;

  logic            is_div, div_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs, div_q, div_r, div_out;
  logic [XLEN:0]   shifted, diff;
  logic [31:0]     w_res;
  logic            cond;

  assign is_div     = (ALU_ctrl2 >= 5'd16) && (ALU_ctrl2 <= 5'd19);
  assign div_signed = (ALU_ctrl2 == 5'd16) || (ALU_ctrl2 == 5'd18);
  assign a_neg      = div_signed & src_a[XLEN-1];
  assign b_neg      = div_signed & src_b[XLEN-1];
  assign a_abs      = a_neg ? -src_a : src_a;
  assign b_abs      = b_neg ? -src_b : src_b;

  // Restoring step: quotient register doubles as the dividend shift register.
  assign shifted = {rem_reg, quo_reg[XLEN-1]};
  assign diff    = shifted - {1'b0, dsr_reg};

  assign div_q   = neg_q_reg ? -quo_reg : quo_reg;
  assign div_r   = neg_r_reg ? -rem_reg : rem_reg;
  assign div_out = is_rem_reg ? div_r : div_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      quo_reg    <= '0;
      rem_reg    <= '0;
      dsr_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      is_rem_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      quo_reg    <= quo_next;
      rem_reg    <= rem_next;
      dsr_reg    <= dsr_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      is_rem_reg <= is_rem_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    quo_next    = quo_reg;
    rem_next    = rem_reg;
    dsr_next    = dsr_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    is_rem_next = is_rem_reg;
    ready4      = 1'b0;
    case (state_reg)
      IDLE: begin
        ready4 = ready5 & ~(valid4 & is_div);
        if (valid4 && is_div) begin
          is_rem_next = ALU_ctrl2[1];
          if (src_b == '0) begin
            quo_next   = '1;
            rem_next   = src_a;
            neg_q_next = 1'b0;
            neg_r_next = 1'b0;
            state_next = DONE;
          end else if (div_signed && src_a == INT_MIN && src_b == '1) begin
            quo_next   = INT_MIN;
            rem_next   = '0;
            neg_q_next = 1'b0;
            neg_r_next = 1'b0;
            state_next = DONE;
          end else begin
            quo_next   = a_abs;
            rem_next   = '0;
            dsr_next   = b_abs;
            neg_q_next = a_neg ^ b_neg;
            neg_r_next = a_neg;
            cnt_next   = CW'(DIV_CYCLES);
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (!diff[XLEN]) begin
          rem_next = diff[XLEN-1:0];
          quo_next = {quo_reg[XLEN-2:0], 1'b1};
        end else begin
          rem_next = shifted[XLEN-1:0];
          quo_next = {quo_reg[XLEN-2:0], 1'b0};
        end
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) state_next = DONE;
      end
      DONE: begin
        ready4 = ready5;
        if (valid4 && ready5) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    w_res  = '0;
    result = '0;
    case (ALU_ctrl2)
      5'd0:  result = src_a + src_b;
      5'd1:  result = src_a - src_b;
      5'd2:  result = src_a << src_b[5:0];
      5'd3:  result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      5'd4:  result = {{(XLEN-1){1'b0}}, src_a < src_b};
      5'd5:  result = src_a ^ src_b;
      5'd6:  result = src_a >> src_b[5:0];
      5'd7:  result = $signed(src_a) >>> src_b[5:0];
      5'd8:  result = src_a | src_b;
      5'd9:  result = src_a & src_b;
      5'd10, 5'd11, 5'd12, 5'd13, 5'd14: begin
        case (ALU_ctrl2)
          5'd10:   w_res = src_a[31:0] + src_b[31:0];
          5'd11:   w_res = src_a[31:0] - src_b[31:0];
          5'd12:   w_res = src_a[31:0] << src_b[4:0];
          5'd13:   w_res = src_a[31:0] >> src_b[4:0];
          default: w_res = $signed(src_a[31:0]) >>> src_b[4:0];
        endcase
        result = {{(XLEN-32){w_res[31]}}, w_res};
      end
      5'd15: result = src_a * src_b;
      5'd16, 5'd17, 5'd18, 5'd19: result = div_out;
      default: result = '0;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (Ins3[14:12])
      3'b000:  cond = (src_a == src_b);
      3'b001:  cond = (src_a != src_b);
      3'b100:  cond = ($signed(src_a) < $signed(src_b));
      3'b101:  cond = ($signed(src_a) >= $signed(src_b));
      3'b110:  cond = (src_a < src_b);
      3'b111:  cond = (src_a >= src_b);
      default: cond = 1'b0;
    endcase
  end

  assign Brch_taken = valid4 & Brch2 & cond;
  assign Brch_PC    = PC4 + {{(XLEN-13){BImm2[11]}}, BImm2, 1'b0};
  assign rdest1_    = rdest1;
  assign reg_w_en3_ = valid4 & reg_w_en2;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid5    <= 1'b0;
      PC5       <= '0;
      Ins4      <= '0;
      MEM_W_en3 <= 1'b0;
      WB_sel3   <= 1'b0;
      reg_w_en3 <= 1'b0;
      rdest2_o  <= '0;
      result1   <= '0;
      rt_data2  <= '0;
    end else if (valid4 && ready4) begin
      valid5    <= 1'b1;
      PC5       <= PC4;
      Ins4      <= Ins3;
      MEM_W_en3 <= MEM_W_en2;
      WB_sel3   <= WB_sel2;
      reg_w_en3 <= reg_w_en2;
      rdest2_o  <= rdest1;
      result1   <= result;
      rt_data2  <= rt_data1;
    end else if (ready5) begin
      valid5 <= 1'b0;
    end
  end
endmodule
